// File: rtl/apb_timer_slave.sv
// APB timer peripheral: four memory-mapped registers driving a down-counter
// with a sticky expiry flag and interrupt, plus a phase tracker that flags
// illegal SETUP/ACCESS sequences coming from the bridge. No wait states:
// every legal transfer is exactly one setup cycle plus one access cycle.
module apb_timer_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  H_CLK,
  input  logic                  H_RESET,
  input  logic                  P_SELx,
  input  logic                  P_ENABLE,
  input  logic                  P_WRITE,
  input  logic [ADDR_WIDTH-1:0] P_ADDR,
  input  logic [DATA_WIDTH-1:0] P_WDATA,
  output logic [DATA_WIDTH-1:0] P_RDATA,
  output logic                  TIMER_IRQ,
  output logic                  PROT_ERR
);

  // Word offsets of the registers (P_ADDR[3:2]).
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_VALUE  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // STATUS bit positions.
  localparam int ST_EXPIRED  = 0;
  localparam int ST_PROT_ERR = 1;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_SETUP  = 2'd1,
    PH_ACCESS = 2'd2
  } phase_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  phase_t                 phase_reg, phase_next;
  logic [1:0]             addr_reg;
  logic                   write_reg;
  logic [DATA_WIDTH-1:0]  rdata_reg;
  logic                   ctrl_en_reg;
  logic                   ctrl_periodic_reg;
  logic                   ctrl_irq_en_reg;
  logic [CNT_WIDTH-1:0]   load_reg;
  logic [CNT_WIDTH-1:0]   value_reg, value_next;
  logic [1:0]             status_reg, status_next;

  // Phase decode results
  logic                   setup_cycle;   // SEL&!EN cycle that (re)enters SETUP
  logic                   access_cycle;  // the legal SETUP->ACCESS cycle
  logic                   prot_err_set;  // illegal phase sequence seen this cycle

  // Write strobes (only on the legal access cycle of a write transfer)
  logic                   wr_commit;
  logic                   ctrl_wr;
  logic                   load_wr;
  logic                   status_wr;

  logic                   expired_set;
  logic [1:0]             status_set;
  logic [DATA_WIDTH-1:0]  read_data;

  // Address bits outside [3:2] and high write-data bits are intentionally
  // not decoded; fold them into one named sink so they are visibly ignored.
  logic                   unused_bits;
  assign unused_bits = ^{P_ADDR[ADDR_WIDTH-1:4], P_ADDR[1:0], P_WDATA};

  // ---------------------------------------------------------------------
  // Phase tracker
  // ---------------------------------------------------------------------

  // Phase register.
  always_ff @(posedge H_CLK) begin
    if (H_RESET) begin
      phase_reg <= PH_IDLE;
    end else begin
      phase_reg <= phase_next;
    end
  end

  // Next phase and classification of the current bus cycle.
  always_comb begin
    phase_next   = phase_reg;
    setup_cycle  = 1'b0;
    access_cycle = 1'b0;
    prot_err_set = 1'b0;
    case (phase_reg)
      PH_IDLE: begin
        if (P_SELx && !P_ENABLE) begin
          phase_next  = PH_SETUP;
          setup_cycle = 1'b1;
        end else if (P_SELx && P_ENABLE) begin
          // Access strobe without a setup: flag it, touch nothing.
          prot_err_set = 1'b1;
        end
      end
      PH_SETUP: begin
        if (!P_SELx) begin
          // Setup abandoned before its access phase.
          prot_err_set = 1'b1;
          phase_next   = PH_IDLE;
        end else if (P_ENABLE) begin
          phase_next   = PH_ACCESS;
          access_cycle = 1'b1;
        end else begin
          // Repeated setup: flag it but treat it as a fresh setup.
          prot_err_set = 1'b1;
          setup_cycle  = 1'b1;
        end
      end
      PH_ACCESS: begin
        if (!P_SELx) begin
          phase_next = PH_IDLE;
        end else if (!P_ENABLE) begin
          // Back-to-back transfer.
          phase_next  = PH_SETUP;
          setup_cycle = 1'b1;
        end else begin
          // Stretched access: no wait states exist, so no second write.
          prot_err_set = 1'b1;
        end
      end
      default: begin
        phase_next = PH_IDLE;
      end
    endcase
  end

  // Capture the transfer's address and direction during each setup cycle.
  always_ff @(posedge H_CLK) begin
    if (H_RESET) begin
      addr_reg  <= 2'd0;
      write_reg <= 1'b0;
    end else if (setup_cycle) begin
      addr_reg  <= P_ADDR[3:2];
      write_reg <= P_WRITE;
    end
  end

  assign wr_commit = access_cycle && write_reg;
  assign ctrl_wr   = wr_commit && (addr_reg == REG_CTRL);
  assign load_wr   = wr_commit && (addr_reg == REG_LOAD);
  assign status_wr = wr_commit && (addr_reg == REG_STATUS);

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------

  // Register selected by the address currently on the bus (setup cycle).
  always_comb begin
    read_data = '0;
    case (P_ADDR[3:2])
      REG_CTRL:   read_data = DATA_WIDTH'({ctrl_irq_en_reg, ctrl_periodic_reg, ctrl_en_reg});
      REG_LOAD:   read_data = DATA_WIDTH'(load_reg);
      REG_VALUE:  read_data = DATA_WIDTH'(value_reg);
      REG_STATUS: read_data = DATA_WIDTH'(status_reg);
      default:    read_data = '0;
    endcase
  end

  // Read data is captured at the end of a read setup and then held, so it
  // is stable for the whole access phase and until the next read setup.
  always_ff @(posedge H_CLK) begin
    if (H_RESET) begin
      rdata_reg <= '0;
    end else if (setup_cycle && !P_WRITE) begin
      rdata_reg <= read_data;
    end
  end

  assign P_RDATA = rdata_reg;

  // ---------------------------------------------------------------------
  // Control and reload registers
  // ---------------------------------------------------------------------

  // CTRL and LOAD are plain write-only-on-commit registers.
  always_ff @(posedge H_CLK) begin
    if (H_RESET) begin
      ctrl_en_reg       <= 1'b0;
      ctrl_periodic_reg <= 1'b0;
      ctrl_irq_en_reg   <= 1'b0;
      load_reg          <= '0;
    end else begin
      if (ctrl_wr) begin
        ctrl_en_reg       <= P_WDATA[0];
        ctrl_periodic_reg <= P_WDATA[1];
        ctrl_irq_en_reg   <= P_WDATA[2];
      end
      if (load_wr) begin
        load_reg <= P_WDATA[CNT_WIDTH-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Down-counter
  // ---------------------------------------------------------------------

  // Next count: a LOAD write overrides counting; otherwise count down to
  // zero, then either reload (periodic) or park at zero (one-shot). The
  // expiry event is the 1->0 step only, so LOAD=0 never raises it.
  always_comb begin
    value_next  = value_reg;
    expired_set = 1'b0;
    if (load_wr) begin
      value_next = P_WDATA[CNT_WIDTH-1:0];
    end else if (ctrl_en_reg) begin
      if (value_reg != '0) begin
        value_next = value_reg - CNT_WIDTH'(1);
        if (value_reg == CNT_WIDTH'(1)) begin
          expired_set = 1'b1;
        end
      end else if (ctrl_periodic_reg) begin
        value_next = load_reg;
      end
    end
  end

  // Counter register.
  always_ff @(posedge H_CLK) begin
    if (H_RESET) begin
      value_reg <= '0;
    end else begin
      value_reg <= value_next;
    end
  end

  // ---------------------------------------------------------------------
  // Sticky status flags (write-1-to-clear, a same-edge set wins)
  // ---------------------------------------------------------------------
  assign status_set[ST_EXPIRED]  = expired_set;
  assign status_set[ST_PROT_ERR] = prot_err_set;

  for (genvar gi = 0; gi < 2; gi++) begin : g_status
    assign status_next[gi] = status_set[gi] |
                             (status_reg[gi] & ~(status_wr & P_WDATA[gi]));
  end

  // Status register.
  always_ff @(posedge H_CLK) begin
    if (H_RESET) begin
      status_reg <= 2'b00;
    end else begin
      status_reg <= status_next;
    end
  end

  assign TIMER_IRQ = status_reg[ST_EXPIRED] & ctrl_irq_en_reg;
  assign PROT_ERR  = status_reg[ST_PROT_ERR];

endmodule

// File: tb/tb_apb_timer_slave.sv
// Self-checking bench for apb_timer_slave. Each test task drives APB
// traffic; expected values are queued at stimulus time, observed values
// are queued when the DUT produces them, and the task drains and compares.
module tb_apb_timer_slave;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CW = 16;

  logic          H_CLK = 1'b0;
  logic          H_RESET;
  logic          P_SELx;
  logic          P_ENABLE;
  logic          P_WRITE;
  logic [AW-1:0] P_ADDR;
  logic [DW-1:0] P_WDATA;
  logic [DW-1:0] P_RDATA;
  logic          TIMER_IRQ;
  logic          PROT_ERR;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] got_q[$];

  apb_timer_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .H_CLK    (H_CLK),
    .H_RESET  (H_RESET),
    .P_SELx   (P_SELx),
    .P_ENABLE (P_ENABLE),
    .P_WRITE  (P_WRITE),
    .P_ADDR   (P_ADDR),
    .P_WDATA  (P_WDATA),
    .P_RDATA  (P_RDATA),
    .TIMER_IRQ(TIMER_IRQ),
    .PROT_ERR (PROT_ERR)
  );

  always #5 H_CLK = ~H_CLK;

  // Inputs change on the falling edge; outputs are sampled there too.

  task automatic sb_push(input logic [31:0] exp, input logic [31:0] got, input string name);
    exp_t e;
    e.data = exp;
    e.name = name;
    exp_q.push_back(e);
    got_q.push_back(got);
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge H_CLK);
    P_SELx = 1'b1; P_ENABLE = 1'b0; P_WRITE = 1'b1; P_ADDR = addr; P_WDATA = data;
    @(negedge H_CLK);
    P_ENABLE = 1'b1;
  endtask

  task automatic apb_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
    exp_t e;
    @(negedge H_CLK);
    P_SELx = 1'b1; P_ENABLE = 1'b0; P_WRITE = 1'b0; P_ADDR = addr;
    e.data = exp;
    e.name = name;
    exp_q.push_back(e);
    @(negedge H_CLK);
    P_ENABLE = 1'b1;
    got_q.push_back(P_RDATA);
  endtask

  task automatic apb_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge H_CLK);
      P_SELx = 1'b0; P_ENABLE = 1'b0; P_WRITE = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge H_CLK);
    H_RESET = 1'b1; P_SELx = 1'b0; P_ENABLE = 1'b0; P_WRITE = 1'b0;
    @(negedge H_CLK);
    H_RESET = 1'b0;
  endtask

  task automatic test_reset();
    exp_t        e;
    logic [31:0] g;
    H_RESET = 1'b1; P_SELx = 1'b0; P_ENABLE = 1'b0; P_WRITE = 1'b0;
    P_ADDR = '0; P_WDATA = '0;
    repeat (3) @(negedge H_CLK);
    H_RESET = 1'b0;
    sb_push(32'h0, P_RDATA, "reset_rdata");
    sb_push(32'h0, 32'(TIMER_IRQ), "reset_irq");
    sb_push(32'h0, 32'(PROT_ERR), "reset_prot_err");
    apb_read(32'h0, 32'h0, "reset_ctrl");
    apb_read(32'h4, 32'h0, "reset_load");
    apb_read(32'h8, 32'h0, "reset_value");
    apb_read(32'hC, 32'h0, "reset_status");
    apb_idle(1);
    sb_push(32'h0, 32'(TIMER_IRQ), "reset_irq_after_reads");
    // LOAD truncates to the counter width and also loads VALUE; VALUE
    // ignores writes.
    apb_write(32'h4, 32'hABCD_1234);
    apb_write(32'h8, 32'h0000_0055);
    apb_read(32'h4, 32'h0000_1234, "load_truncate");
    apb_read(32'h8, 32'h0000_1234, "value_follows_load");
    apb_idle(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e.data) begin
        failures++;
        $display("FAIL %s actual=%h required=%h", e.name, g, e.data);
      end else $display("ok   %s value=%h", e.name, g);
    end
  endtask

  task automatic test_oneshot();
    exp_t        e;
    logic [31:0] g;
    do_reset();
    apb_write(32'h4, 32'd5);                  // commit p2
    apb_read(32'h8, 32'd5, "oneshot_value_loaded");
    apb_write(32'h0, 32'h5);                  // EN, IRQ_EN commit p6
    // Decrements on p7..p11; VALUE reaches 0 and IRQ rises after p11.
    for (int k = 6; k <= 11; k++) begin
      @(negedge H_CLK);
      if (k == 6) begin P_SELx = 1'b0; P_ENABLE = 1'b0; end
      sb_push((k == 11) ? 32'h1 : 32'h0, 32'(TIMER_IRQ), $sformatf("oneshot_irq_n%0d", k));
    end
    apb_read(32'h8, 32'h0, "oneshot_value_zero");
    apb_read(32'hC, 32'h1, "oneshot_status_expired");
    apb_idle(4);
    apb_read(32'h8, 32'h0, "oneshot_value_holds");
    apb_idle(1);
    sb_push(32'h1, 32'(TIMER_IRQ), "oneshot_irq_sticky");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e.data) begin
        failures++;
        $display("FAIL %s actual=%h required=%h", e.name, g, e.data);
      end else $display("ok   %s value=%h", e.name, g);
    end
  endtask

  task automatic test_periodic();
    exp_t        e;
    logic [31:0] g;
    do_reset();
    apb_write(32'h4, 32'd3);                  // commit p2
    apb_write(32'h0, 32'h3);                  // EN, PERIODIC commit p4
    // VALUE after edge pk (k>=4): 3,2,1,0 repeating; EXPIRED sets p7,p11,p15,p19.
    apb_read(32'h8, 32'd3, "periodic_v4");
    apb_read(32'h8, 32'd1, "periodic_v6");
    apb_idle(1);
    apb_read(32'h8, 32'd2, "periodic_v9");
    apb_read(32'h8, 32'd0, "periodic_v11");
    apb_read(32'hC, 32'h1, "periodic_expired");
    apb_write(32'hC, 32'h1);                  // W1C commit p17
    apb_read(32'hC, 32'h0, "periodic_w1c_cleared");
    apb_read(32'hC, 32'h1, "periodic_expired_again");
    apb_idle(1);
    sb_push(32'h0, 32'(TIMER_IRQ), "periodic_irq_masked");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e.data) begin
        failures++;
        $display("FAIL %s actual=%h required=%h", e.name, g, e.data);
      end else $display("ok   %s value=%h", e.name, g);
    end
  endtask

  task automatic test_collision();
    exp_t        e;
    logic [31:0] g;
    do_reset();
    apb_write(32'h4, 32'd3);                  // commit p2
    apb_write(32'h0, 32'h3);                  // commit p4
    apb_write(32'h4, 32'd7);                  // commit p6, decrement also due
    apb_read(32'h8, 32'd7, "collide_load_wins");
    apb_idle(3);
    // VALUE 7 after p6 reaches 0 on p13; the W1C commits on p13 as well.
    apb_write(32'hC, 32'h1);
    apb_read(32'hC, 32'h1, "collide_set_beats_w1c");
    apb_write(32'hC, 32'h1);                  // plain W1C, commit p16
    apb_read(32'hC, 32'h0, "collide_w1c_later");
    apb_read(32'h4, 32'd7, "collide_load_reg");
    apb_idle(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e.data) begin
        failures++;
        $display("FAIL %s actual=%h required=%h", e.name, g, e.data);
      end else $display("ok   %s value=%h", e.name, g);
    end
  endtask

  task automatic test_prot_err();
    exp_t        e;
    logic [31:0] g;
    do_reset();
    // Access strobe with no setup, carrying write data that must not land.
    @(negedge H_CLK);
    P_SELx = 1'b1; P_ENABLE = 1'b1; P_WRITE = 1'b1; P_ADDR = 32'h4; P_WDATA = 32'h55;
    @(negedge H_CLK);
    sb_push(32'h1, 32'(PROT_ERR), "prot_idle_enable");
    // Legal setup + access writing 0xA, then a stretched second access cycle.
    P_ENABLE = 1'b0; P_WDATA = 32'hA;
    @(negedge H_CLK);
    P_ENABLE = 1'b1;
    @(negedge H_CLK);
    P_WDATA = 32'h77;
    apb_idle(1);
    apb_read(32'h4, 32'hA, "prot_load_once");
    apb_read(32'h8, 32'hA, "prot_value_once");
    apb_read(32'hC, 32'h2, "prot_status");
    apb_write(32'hC, 32'h2);
    apb_idle(1);
    sb_push(32'h0, 32'(PROT_ERR), "prot_w1c");
    // Setup abandoned without an access phase.
    @(negedge H_CLK);
    P_SELx = 1'b1; P_ENABLE = 1'b0; P_WRITE = 1'b0; P_ADDR = 32'h0;
    apb_idle(1);
    @(negedge H_CLK);
    sb_push(32'h1, 32'(PROT_ERR), "prot_setup_dropped");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e.data) begin
        failures++;
        $display("FAIL %s actual=%h required=%h", e.name, g, e.data);
      end else $display("ok   %s value=%h", e.name, g);
    end
  endtask

  task automatic test_reset_mid_transfer();
    exp_t        e;
    logic [31:0] g;
    do_reset();
    apb_write(32'h0, 32'hFFFF_FFFE);          // PERIODIC + IRQ_EN, EN off
    apb_read(32'h0, 32'h6, "midrst_ctrl_before");
    apb_idle(1);
    @(negedge H_CLK);
    P_SELx = 1'b1; P_ENABLE = 1'b0; P_WRITE = 1'b1; P_ADDR = 32'h0; P_WDATA = 32'h7;
    @(negedge H_CLK);
    P_ENABLE = 1'b1; H_RESET = 1'b1;
    @(negedge H_CLK);
    H_RESET = 1'b0; P_SELx = 1'b0; P_ENABLE = 1'b0; P_WRITE = 1'b0;
    sb_push(32'h0, P_RDATA, "midrst_rdata");
    sb_push(32'h0, 32'(PROT_ERR), "midrst_prot_err");
    apb_read(32'h0, 32'h0, "midrst_ctrl_after");
    apb_idle(1);
    sb_push(32'h0, 32'(PROT_ERR), "midrst_fsm_idle");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e.data) begin
        failures++;
        $display("FAIL %s actual=%h required=%h", e.name, g, e.data);
      end else $display("ok   %s value=%h", e.name, g);
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_collision();
    test_prot_err();
    test_reset_mid_transfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
